instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Sequencer on the issuing side of the multicycle control-unit handshake. It holds the PC and fetches each instruction from instruction memory through a req/ack handshake. It presents the instruction and its opcode to the control unit, then waits for the control unit's `finished` pulse before computing the next PC and fetching again. It also halts on ECALL or on a misaligned branch target.

Parameters:
- WORDSIZE, 64, width of PC and address bus
- INSTRUCTION_SIZE, 32, instruction width
- RESET_PC, 0, PC value after reset
- PC_STEP, 4, sequential PC increment in bytes

Ports:
- clk  in  1  system clock; all state changes on posedge
- rst  in  1  asynchronous reset, active-high
- start  in  1  begin fetching; sampled in IDLE only
- im_req  out  1  instruction-memory read request
- im_addr  out  WORDSIZE  fetch address; equals pc
- im_ack  in  1  memory read-data valid; honoured only while im_req=1
- im_rdata  in  INSTRUCTION_SIZE  fetched instruction word
- instruction  out  INSTRUCTION_SIZE  latched instruction presented to datapath
- opcode  out  7  instruction[6:0]
- instr_valid  out  1  instruction/opcode valid for the control unit
- finished  in  1  control-unit completion pulse; honoured only while instr_valid=1
- branch_taken  in  1  sampled with finished; select branch_target
- branch_target  in  WORDSIZE  next PC when branch_taken=1
- pc  out  WORDSIZE  current PC
- retired  out  32  count of completed instructions
- halted  out  1  fetch stopped (ECALL or error)
- error  out  1  misaligned-target trap

Behaviour:
- Reset (async, immediate):
  - state=IDLE, pc=RESET_PC, im_req=0, instruction=0, instr_valid=0, retired=0, halted=0, error=0.
  - Reset mid-transaction drops im_req and instr_valid in the same instant.
- States: IDLE, REQ, EXEC, HALTED. All outputs are registered.
- IDLE: when start=1 at a posedge, im_req is set to 1 and the state moves to REQ.
- REQ:
  - im_req=1 and im_addr=pc, held stable until im_ack.
  - At a posedge with im_ack=1: latch im_rdata into instruction, set instr_valid=1, clear im_req, go to EXEC.
  - A zero-wait memory (im_ack tied to im_req) gives instr_valid one cycle after im_req rises.
- EXEC:
  - instruction and instr_valid are held until finished=1 at a posedge.
  - On that edge:
    - pc <= branch_taken ? branch_target : pc+PC_STEP
    - retired <= retired+1
    - instr_valid <= 0
  - Then one of the following, in priority order:
    1. branch_taken=1 and branch_target[1:0]!=0: pc is not updated (keeps the faulting instruction's PC), error=1, halted=1, go to HALTED.
    2. opcode==7'b1110011 (ECALL/EBREAK): pc is updated as above, halted=1, go to HALTED.
    3. Otherwise im_req=1 at the same edge (back-to-back fetch), go to REQ.
- HALTED: terminal state. im_req=0, instr_valid=0, start is ignored. Exit only via rst.
- Ignored inputs:
  - start outside IDLE.
  - im_ack outside REQ, which includes an ack arriving in the same cycle as a finished pulse.
  - finished outside EXEC.
  - branch_taken without finished.
- Arithmetic:
  - pc+PC_STEP wraps modulo 2^WORDSIZE, no trap.
  - retired wraps modulo 2^32.
  - An RF-only instruction costs 1 fetch cycle plus memory wait plus control-unit cycles.

Decomposition:
- Shared package `riscv_pkg`:
  - opcode localparams (R, I, I_load, S, B, J, J_I, U, U_PC, E), shared with control_unit
  - fetch state encoding (IDLE, REQ, EXEC, HALTED)
  - PC_STEP default
- One sub-module, `fetch_next_pc` (combinational): inputs pc, branch_taken, branch_target; outputs next_pc and misaligned. Keeps the PC arithmetic separately testable.

Test Plan:
1. Reset, then start=1; zero-wait memory returns 0x00500093. Required: im_addr=0, then instr_valid=1 with opcode=0x13. Pulse finished → pc=4, retired=1, im_req=1 with im_addr=4 at the same edge.
2. im_ack delayed 3 cycles. Required: im_req held at 1, im_addr stable at 4, instr_valid=0 until the ack edge; instruction is latched only on the ack edge. A spurious im_ack during EXEC leaves instruction unchanged.
3. finished with branch_taken=1 and branch_target=0x40. Required: pc=0x40, next im_addr=0x40. With branch_taken=0, pc=0x44.
4. finished with branch_taken=1 and branch_target=0x42. Required: error=1, halted=1, pc unchanged, im_req stays 0, and a later start=1 has no effect.
5. Fetch 0x00000073 (ECALL) at pc=8, then pulse finished. Required: pc=0xC, retired incremented, halted=1, error=0, no further im_req.
6. Assert rst mid-EXEC and mid-REQ (asynchronously, between edges). Required: instr_valid=0, im_req=0, pc=RESET_PC, retired=0 immediately. After rst release, start=1 refetches address 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V core: opcode values decoded by
// the control unit and the fetch sequencer, fetch-state encoding and the
// default sequential PC increment.
package riscv_pkg;

   // Major opcodes (instruction[6:0])
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_I_LOAD = 7'b0000011;
   localparam logic [6:0] OP_S      = 7'b0100011;
   localparam logic [6:0] OP_B      = 7'b1100011;
   localparam logic [6:0] OP_J      = 7'b1101111;
   localparam logic [6:0] OP_J_I    = 7'b1100111;
   localparam logic [6:0] OP_U      = 7'b0110111;
   localparam logic [6:0] OP_U_PC   = 7'b0010111;
   localparam logic [6:0] OP_E      = 7'b1110011;

   // Byte distance between consecutive instructions
   localparam int unsigned PC_STEP_DEFAULT = 4;

   // Fetch sequencer states
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_EXEC,
      ST_HALTED
   } fetch_state_e;

   // ECALL/EBREAK share the SYSTEM opcode; either one stops fetching
   function automatic logic is_system(input logic [6:0] op);
      return op == OP_E;
   endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection for the fetch sequencer: either the branch target or the
// sequential successor, plus a flag for a taken branch whose target is not
// word aligned. Sequential increment wraps silently at the top of the space.
module fetch_next_pc
   import riscv_pkg::*;
#(
   parameter int unsigned WORDSIZE = 64,
   parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
   input  logic [WORDSIZE-1:0] pc,
   input  logic                branch_taken,
   input  logic [WORDSIZE-1:0] branch_target,
   output logic [WORDSIZE-1:0] next_pc,
   output logic                misaligned
);

   localparam logic [WORDSIZE-1:0] STEP = WORDSIZE'(PC_STEP);

   assign next_pc    = branch_taken ? branch_target : pc + STEP;
   assign misaligned = branch_taken && (branch_target[1:0] != 2'b00);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch sequencer on the issuing side of the multicycle control-unit
// handshake: fetches one instruction via im_req/im_ack, presents it with
// instr_valid, waits for the control unit's finished pulse, then advances the
// PC and fetches again. Stops for good on ECALL/EBREAK or on a misaligned
// taken-branch target; only rst leaves the halted state.
module instruction_fetch_unit
   import riscv_pkg::*;
#(
   parameter int unsigned          WORDSIZE         = 64,
   parameter int unsigned          INSTRUCTION_SIZE = 32,
   parameter logic [WORDSIZE-1:0]  RESET_PC         = '0,
   parameter int unsigned          PC_STEP          = PC_STEP_DEFAULT
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   output logic                        im_req,
   output logic [WORDSIZE-1:0]         im_addr,
   input  logic                        im_ack,
   input  logic [INSTRUCTION_SIZE-1:0] im_rdata,
   output logic [INSTRUCTION_SIZE-1:0] instruction,
   output logic [6:0]                  opcode,
   output logic                        instr_valid,
   input  logic                        finished,
   input  logic                        branch_taken,
   input  logic [WORDSIZE-1:0]         branch_target,
   output logic [WORDSIZE-1:0]         pc,
   output logic [31:0]                 retired,
   output logic                        halted,
   output logic                        error
);

   fetch_state_e                state_q, state_d;
   logic [WORDSIZE-1:0]         pc_q, pc_d;
   logic [INSTRUCTION_SIZE-1:0] instr_q, instr_d;
   logic                        im_req_q, im_req_d;
   logic                        instr_valid_q, instr_valid_d;
   logic [31:0]                 retired_q, retired_d;
   logic                        halted_q, halted_d;
   logic                        error_q, error_d;

   logic [WORDSIZE-1:0]         next_pc;
   logic                        misaligned;

   fetch_next_pc #(
      .WORDSIZE (WORDSIZE),
      .PC_STEP  (PC_STEP)
   ) u_next_pc (
      .pc            (pc_q),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .next_pc       (next_pc),
      .misaligned    (misaligned)
   );

   // Next-state and registered-output decode for the fetch sequencer
   always_comb begin
      // NOTE: every _d gets its hold value first so no path through the case
      // leaves a signal unassigned, which would otherwise infer a latch.
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      im_req_d      = im_req_q;
      instr_valid_d = instr_valid_q;
      retired_d     = retired_q;
      halted_d      = halted_q;
      error_d       = error_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               im_req_d = 1'b1;
               state_d  = ST_REQ;
            end
         end

         ST_REQ: begin
            // im_req is always high here, so im_ack alone completes the read
            if (im_ack) begin
               instr_d       = im_rdata;
               instr_valid_d = 1'b1;
               im_req_d      = 1'b0;
               state_d       = ST_EXEC;
            end
         end

         ST_EXEC: begin
            if (finished) begin
               retired_d     = retired_q + 32'd1;
               instr_valid_d = 1'b0;
               if (misaligned) begin
                  // Keep the faulting instruction's PC for post-mortem
                  error_d  = 1'b1;
                  halted_d = 1'b1;
                  state_d  = ST_HALTED;
               end else if (is_system(instr_q[6:0])) begin
                  pc_d     = next_pc;
                  halted_d = 1'b1;
                  state_d  = ST_HALTED;
               end else begin
                  pc_d     = next_pc;
                  im_req_d = 1'b1;
                  state_d  = ST_REQ;
               end
            end
         end

         ST_HALTED: begin
            im_req_d      = 1'b0;
            instr_valid_d = 1'b0;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of its inputs regardless of statement order.
      if (rst) begin
         state_q       <= ST_IDLE;
         pc_q          <= RESET_PC;
         instr_q       <= '0;
         im_req_q      <= 1'b0;
         instr_valid_q <= 1'b0;
         retired_q     <= '0;
         halted_q      <= 1'b0;
         error_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         im_req_q      <= im_req_d;
         instr_valid_q <= instr_valid_d;
         retired_q     <= retired_d;
         halted_q      <= halted_d;
         error_q       <= error_d;
      end
   end

   assign im_req      = im_req_q;
   assign im_addr     = pc_q;
   assign instruction = instr_q;
   assign opcode      = instr_q[6:0];
   assign instr_valid = instr_valid_q;
   assign pc          = pc_q;
   assign retired     = retired_q;
   assign halted      = halted_q;
   assign error       = error_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed stimulus pushes the
// expected fetch addresses, latched instructions, retirements and halts into
// queues; a negedge monitor pops and compares whenever the DUT shows the
// corresponding event.
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        im_req;
   logic [63:0] im_addr;
   logic        im_ack;
   logic [31:0] im_rdata;
   logic [31:0] instruction;
   logic [6:0]  opcode;
   logic        instr_valid;
   logic        finished;
   logic        branch_taken;
   logic [63:0] branch_target;
   logic [63:0] pc;
   logic [31:0] retired;
   logic        halted;
   logic        error;

   // Memory model: zero-wait (ack follows req) or manually driven ack
   logic zw;
   logic ack_m;
   assign im_ack = zw ? im_req : ack_m;

   always #5 clk = ~clk;

   instruction_fetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .im_req        (im_req),
      .im_addr       (im_addr),
      .im_ack        (im_ack),
      .im_rdata      (im_rdata),
      .instruction   (instruction),
      .opcode        (opcode),
      .instr_valid   (instr_valid),
      .finished      (finished),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .pc            (pc),
      .retired       (retired),
      .halted        (halted),
      .error         (error)
   );

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] ret;
   } ret_exp_t;

   typedef struct packed {
      logic [63:0] pc;
      logic        err;
   } halt_exp_t;

   logic [63:0] exp_addr_q[$];
   logic [31:0] exp_instr_q[$];
   ret_exp_t    exp_ret_q[$];
   halt_exp_t   exp_halt_q[$];

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic unexpected(input string name);
      n_total++;
      $display("FAIL %s: DUT event with no expectation queued (t=%0t)", name, $time);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Monitor: compare each DUT event against the oldest queued expectation
   initial begin
      logic        p_req, p_valid, p_halt;
      logic [31:0] p_ret;
      ret_exp_t    r;
      halt_exp_t   h;
      logic [31:0] w;
      p_req = 0; p_valid = 0; p_halt = 0; p_ret = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (im_req && !p_req) begin
               if (exp_addr_q.size() != 0) check("fetch_addr", im_addr, exp_addr_q.pop_front());
               else unexpected("fetch_addr");
            end
            if (instr_valid && !p_valid) begin
               if (exp_instr_q.size() != 0) begin
                  w = exp_instr_q.pop_front();
                  check("instruction", {32'd0, instruction}, {32'd0, w});
                  check("opcode", {57'd0, opcode}, {57'd0, w[6:0]});
               end else unexpected("instr_valid");
            end
            if (retired != p_ret) begin
               if (exp_ret_q.size() != 0) begin
                  r = exp_ret_q.pop_front();
                  check("retire_pc", pc, r.pc);
                  check("retired", {32'd0, retired}, {32'd0, r.ret});
               end else unexpected("retire");
            end
            if (halted && !p_halt) begin
               if (exp_halt_q.size() != 0) begin
                  h = exp_halt_q.pop_front();
                  check("halt_pc", pc, h.pc);
                  check("halt_error", {63'd0, error}, {63'd0, h.err});
               end else unexpected("halt");
            end
         end
         p_req   = im_req;
         p_valid = instr_valid;
         p_halt  = halted;
         p_ret   = retired;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic fetch_ack(input logic [31:0] word);
      im_rdata = word;
      exp_instr_q.push_back(word);
      ack_m = 1'b1;
      tick();
      ack_m = 1'b0;
   endtask

   task automatic finish(input logic taken, input logic [63:0] tgt,
                         input logic [63:0] exp_pc, input logic [31:0] exp_ret,
                         input bit refetch);
      finished      = 1'b1;
      branch_taken  = taken;
      branch_target = tgt;
      exp_ret_q.push_back('{pc: exp_pc, ret: exp_ret});
      if (refetch) exp_addr_q.push_back(exp_pc);
      tick();
      finished     = 1'b0;
      branch_taken = 1'b0;
   endtask

   // Assert rst between edges, check the immediate effect, release later
   task automatic do_reset(input string tag);
      #2 rst = 1'b1;
      #1;
      check({tag, "_im_req"},      {63'd0, im_req},      64'd0);
      check({tag, "_instr_valid"}, {63'd0, instr_valid}, 64'd0);
      check({tag, "_pc"},          pc,                   64'd0);
      check({tag, "_retired"},     {32'd0, retired},     64'd0);
      check({tag, "_halted"},      {63'd0, halted},      64'd0);
      check({tag, "_error"},       {63'd0, error},       64'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; finished = 1'b0; branch_taken = 1'b0;
      branch_target = '0; zw = 1'b0; ack_m = 1'b0; im_rdata = '0;

      // Reset state
      tick();
      check("rst_im_req",      {63'd0, im_req},      64'd0);
      check("rst_instr_valid", {63'd0, instr_valid}, 64'd0);
      check("rst_pc",          pc,                   64'd0);
      check("rst_retired",     {32'd0, retired},     64'd0);
      check("rst_halted",      {63'd0, halted},      64'd0);
      check("rst_error",       {63'd0, error},       64'd0);
      check("rst_instruction", {32'd0, instruction}, 64'd0);
      #2 rst = 1'b0;
      tick();

      // 1: zero-wait fetch, then back-to-back refetch on finished
      zw = 1'b1;
      im_rdata = 32'h0050_0093;
      exp_addr_q.push_back(64'h0);
      exp_instr_q.push_back(32'h0050_0093);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t1_req_high",   {63'd0, im_req},      64'd1);
      check("t1_valid_low",  {63'd0, instr_valid}, 64'd0);
      tick();
      check("t1_valid_high", {63'd0, instr_valid}, 64'd1);
      check("t1_opcode",     {57'd0, opcode},      64'h13);
      check("t1_req_low",    {63'd0, im_req},      64'd0);
      zw = 1'b0;
      finish(1'b0, 64'h0, 64'h4, 32'd1, 1'b1);
      check("t1_req_same_edge", {63'd0, im_req}, 64'd1);
      check("t1_addr_4",        im_addr,         64'h4);

      // 2: delayed ack, then spurious ack in EXEC
      im_rdata = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t2_req_held",   {63'd0, im_req},      64'd1);
         check("t2_addr_held",  im_addr,              64'h4);
         check("t2_valid_low",  {63'd0, instr_valid}, 64'd0);
         check("t2_instr_held", {32'd0, instruction}, 64'h0050_0093);
      end
      fetch_ack(32'h0010_8113);
      im_rdata = 32'hFFFF_FFFF;
      ack_m = 1'b1;
      tick();
      ack_m = 1'b0;
      check("t2_spurious_instr", {32'd0, instruction}, 64'h0010_8113);
      check("t2_spurious_valid", {63'd0, instr_valid}, 64'd1);
      check("t2_spurious_req",   {63'd0, im_req},      64'd0);

      // 3: taken branch (with an ack coinciding with finished), then not taken
      ack_m = 1'b1;
      im_rdata = 32'hCAFE_F00D;
      finish(1'b1, 64'h40, 64'h40, 32'd2, 1'b1);
      ack_m = 1'b0;
      check("t3_pc_40",      pc,                   64'h40);
      check("t3_addr_40",    im_addr,              64'h40);
      check("t3_ack_ignored", {32'd0, instruction}, 64'h0010_8113);
      check("t3_valid_low",  {63'd0, instr_valid}, 64'd0);
      fetch_ack(32'h0020_81B3);
      branch_taken = 1'b1;
      branch_target = 64'h80;
      tick();
      branch_taken = 1'b0;
      check("t3_taken_no_fin_pc", pc, 64'h40);
      check("t3_taken_no_fin_valid", {63'd0, instr_valid}, 64'd1);
      finish(1'b0, 64'h43, 64'h44, 32'd3, 1'b1);
      check("t3_pc_44",    pc,              64'h44);
      check("t3_no_error", {63'd0, error},  64'd0);

      // 4: misaligned taken target traps, start ignored afterwards
      fetch_ack(32'h0000_0063);
      exp_halt_q.push_back('{pc: 64'h44, err: 1'b1});
      finish(1'b1, 64'h42, 64'h44, 32'd4, 1'b0);
      check("t4_pc_kept", pc,               64'h44);
      check("t4_error",   {63'd0, error},   64'd1);
      check("t4_halted",  {63'd0, halted},  64'd1);
      check("t4_req_low", {63'd0, im_req},  64'd0);
      start = 1'b1;
      repeat (3) tick();
      start = 1'b0;
      check("t4_start_ignored_req", {63'd0, im_req},      64'd0);
      check("t4_start_ignored_val", {63'd0, instr_valid}, 64'd0);
      check("t4_still_halted",      {63'd0, halted},      64'd1);

      do_reset("t4_rst_halted");

      // 5: two NOPs then ECALL at pc=8
      zw = 1'b1;
      im_rdata = 32'h0000_0013;
      exp_addr_q.push_back(64'h0);
      exp_instr_q.push_back(32'h0000_0013);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      exp_instr_q.push_back(32'h0000_0013);
      finish(1'b0, 64'h0, 64'h4, 32'd1, 1'b1);
      tick();
      im_rdata = 32'h0000_0073;
      exp_instr_q.push_back(32'h0000_0073);
      finish(1'b0, 64'h0, 64'h8, 32'd2, 1'b1);
      tick();
      check("t5_ecall_opcode", {57'd0, opcode}, 64'h73);
      check("t5_ecall_pc",     pc,              64'h8);
      exp_halt_q.push_back('{pc: 64'hC, err: 1'b0});
      finish(1'b0, 64'h0, 64'hC, 32'd3, 1'b0);
      check("t5_pc_c",    pc,                64'hC);
      check("t5_retired", {32'd0, retired},  64'd3);
      check("t5_halted",  {63'd0, halted},   64'd1);
      check("t5_error",   {63'd0, error},    64'd0);
      repeat (2) tick();
      check("t5_no_req",  {63'd0, im_req},   64'd0);
      zw = 1'b0;

      do_reset("t5_rst_halted");

      // 6a: reset while waiting for im_ack
      zw = 1'b1;
      im_rdata = 32'h0000_0013;
      exp_addr_q.push_back(64'h0);
      exp_instr_q.push_back(32'h0000_0013);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      zw = 1'b0;
      finish(1'b0, 64'h0, 64'h4, 32'd1, 1'b1);
      tick();
      check("t6_pre_req", {63'd0, im_req}, 64'd1);
      check("t6_pre_pc",  pc,              64'h4);
      do_reset("t6_rst_req");

      // 6b: reset while an instruction is presented
      zw = 1'b1;
      exp_addr_q.push_back(64'h0);
      exp_instr_q.push_back(32'h0000_0013);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      exp_instr_q.push_back(32'h0000_0013);
      finish(1'b0, 64'h0, 64'h4, 32'd1, 1'b1);
      tick();
      zw = 1'b0;
      check("t6_pre_valid", {63'd0, instr_valid}, 64'd1);
      check("t6_pre_pc4",   pc,                   64'h4);
      do_reset("t6_rst_exec");

      // 6c: refetch from RESET_PC after reset
      exp_addr_q.push_back(64'h0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t6_refetch_req",  {63'd0, im_req}, 64'd1);
      check("t6_refetch_addr", im_addr,         64'h0);
      tick();

      check("addr_q_drained",  64'(exp_addr_q.size()),  64'd0);
      check("instr_q_drained", 64'(exp_instr_q.size()), 64'd0);
      check("ret_q_drained",   64'(exp_ret_q.size()),   64'd0);
      check("halt_q_drained",  64'(exp_halt_q.size()),  64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
